// File: rtl/ln4017_decade_tally.sv
// ln4017_decade_tally
//   Consumes the one-hot state and carry of a 4017-style decade counter,
//   decodes the units digit, and counts decade roll-overs into a cascaded BCD
//   tally that can be latched for display.
//
// Ports
//   cp0        clock, rising edge
//   mr         synchronous active-high reset (overrides clr and latch_en)
//   in_q       one-hot counter state
//   q59_n      counter carry, 1 while state is 0..4
//   clr        synchronous clear of the cascade digits and the sticky flags
//   latch_en   capture live units and cascade into the display registers
//   bcd_units  latched units digit
//   bcd_carry  latched cascade digits, nibble 0 = tens
//   live_units decoded units digit from the registered counter state
//   illegal    sticky: a non-one-hot state was sampled
//   ovf        sticky: the cascade wrapped from all-9s to all-0s
module ln4017_decade_tally #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                  cp0,
    input  logic                  mr,
    input  logic [9:0]            in_q,
    input  logic                  q59_n,
    input  logic                  clr,
    input  logic                  latch_en,
    output logic [3:0]            bcd_units,
    output logic [4*DIGITS-1:0]   bcd_carry,
    output logic [3:0]            live_units,
    output logic                  illegal,
    output logic                  ovf
);

    logic [9:0]          s_q;
    logic                s_c;
    logic                c_prev;
    logic [3:0]          held_units;
    logic [4*DIGITS-1:0] cascade;
    logic [4*DIGITS-1:0] cascade_next;
    logic                wrap_all;
    logic                one_hot;
    logic [3:0]          idx;
    logic                carry_event;

    // Decode: live_units tracks the registered state when it is one-hot and
    // otherwise keeps the last legal digit.
    always_comb begin
        idx     = 4'd0;
        one_hot = (s_q != 10'd0) && ((s_q & (s_q - 10'd1)) == 10'd0);
        for (int i = 0; i < 10; i++) begin
            if (s_q[i]) begin
                idx = 4'(i);
            end
        end
        live_units = one_hot ? idx : held_units;
    end

    // Carry rising edge means the counter stepped from 9 to 0.
    assign carry_event = s_c & ~c_prev;

    // Ripple a single increment through the BCD digits within one cycle.
    always_comb begin
        cascade_next = cascade;
        wrap_all     = 1'b1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (wrap_all) begin
                if (cascade[4*d +: 4] == 4'd9) begin
                    cascade_next[4*d +: 4] = 4'd0;
                end else begin
                    cascade_next[4*d +: 4] = cascade[4*d +: 4] + 4'd1;
                    wrap_all               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge cp0) begin
        if (mr) begin
            // s_c and c_prev both 1 so a held-high q59_n after release is no event.
            s_q        <= 10'd1;
            s_c        <= 1'b1;
            c_prev     <= 1'b1;
            held_units <= 4'd0;
            cascade    <= '0;
            bcd_units  <= 4'd0;
            bcd_carry  <= '0;
            illegal    <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            s_q        <= in_q;
            s_c        <= q59_n;
            c_prev     <= s_c;
            held_units <= live_units;

            // Display captures pre-edge values, so it never sees this edge's
            // increment or clear.
            if (latch_en) begin
                bcd_units <= live_units;
                bcd_carry <= cascade;
            end

            if (clr) begin
                cascade <= '0;
                illegal <= 1'b0;
                ovf     <= 1'b0;
            end else begin
                if (!one_hot) begin
                    illegal <= 1'b1;
                end
                if (carry_event) begin
                    cascade <= cascade_next;
                    if (wrap_all) begin
                        ovf <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ln4017_decade_tally.sv
// Directed bench for ln4017_decade_tally (DIGITS = 3). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_ln4017_decade_tally;

    logic        cp0;
    logic        mr;
    logic [9:0]  in_q;
    logic        q59_n;
    logic        clr;
    logic        latch_en;
    logic [3:0]  bcd_units;
    logic [11:0] bcd_carry;
    logic [3:0]  live_units;
    logic        illegal;
    logic        ovf;

    int n_assert = 0;
    int n_fail   = 0;

    ln4017_decade_tally #(.DIGITS(3)) dut (
        .cp0       (cp0),
        .mr        (mr),
        .in_q      (in_q),
        .q59_n     (q59_n),
        .clr       (clr),
        .latch_en  (latch_en),
        .bcd_units (bcd_units),
        .bcd_carry (bcd_carry),
        .live_units(live_units),
        .illegal   (illegal),
        .ovf       (ovf)
    );

    initial cp0 = 1'b0;
    always #5 cp0 = ~cp0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [9:0] q, input logic c, input logic le,
                        input logic cl, input logic r);
        in_q     = q;
        q59_n    = c;
        latch_en = le;
        clr      = cl;
        mr       = r;
        @(posedge cp0);
        #1;
    endtask

    // One legal counter step to state n.
    task automatic step(input int n, input logic le, input logic cl);
        tick(10'(1 << n), (n < 5), le, cl, 1'b0);
    endtask

    task automatic do_reset();
        tick(10'h3ff, 1'b0, 1'b1, 1'b1, 1'b1);
        tick(10'h3ff, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        in_q = 10'd0; q59_n = 1'b0; clr = 1'b0; latch_en = 1'b0; mr = 1'b0;
        @(posedge cp0);
        #1;

        // Reset state
        do_reset();
        chk("rst_live", 32'(live_units), 32'd0);
        chk("rst_units", 32'(bcd_units), 32'd0);
        chk("rst_carry", 32'(bcd_carry), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Walk 0..9, live_units one cycle behind in_q
        for (int n = 0; n < 10; n++) begin
            step(n, 1'b0, 1'b0);
            chk($sformatf("walk_live_%0d", n), 32'(live_units), 32'(n));
        end
        step(9, 1'b1, 1'b0);
        chk("walk_units", 32'(bcd_units), 32'd9);
        chk("walk_carry", 32'(bcd_carry), 32'd0);
        chk("walk_illegal", 32'(illegal), 32'd0);

        // 23 decades plus 4 steps
        do_reset();
        for (int i = 1; i <= 234; i++) step(i % 10, 1'b0, 1'b0);
        step(4, 1'b1, 1'b0);
        chk("roll_units", 32'(bcd_units), 32'd4);
        chk("roll_carry", 32'(bcd_carry), 32'h023);
        chk("roll_ovf", 32'(ovf), 32'd0);

        // Overflow: 999 decades, then one more
        do_reset();
        for (int i = 1; i <= 9992; i++) step(i % 10, (i == 9992), 1'b0);
        chk("pre_ovf_carry", 32'(bcd_carry), 32'h999);
        chk("pre_ovf_flag", 32'(ovf), 32'd0);
        for (int i = 9993; i <= 10002; i++) step(i % 10, (i == 10002), 1'b0);
        chk("ovf_carry", 32'(bcd_carry), 32'h000);
        chk("ovf_flag", 32'(ovf), 32'd1);
        for (int i = 0; i < 3; i++) step(2, 1'b0, 1'b0);
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // Illegal state: live_units holds 2 during the bad cycle
        tick(10'b0000000110, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ill_hold_live", 32'(live_units), 32'd2);
        chk("ill_not_yet", 32'(illegal), 32'd0);
        step(7, 1'b0, 1'b0);
        chk("ill_live7", 32'(live_units), 32'd7);
        chk("ill_set", 32'(illegal), 32'd1);
        step(7, 1'b0, 1'b0);
        chk("ill_sticky", 32'(illegal), 32'd1);

        // clr + latch_en + pending carry event, tally at 0x015
        do_reset();
        tick(10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 160; i++) step(i % 10, 1'b0, 1'b0);
        chk("clr_pre_illegal", 32'(illegal), 32'd1);
        step(1, 1'b1, 1'b1);
        chk("clr_latch_carry", 32'(bcd_carry), 32'h015);
        chk("clr_latch_units", 32'(bcd_units), 32'd0);
        chk("clr_illegal", 32'(illegal), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        step(2, 1'b1, 1'b0);
        chk("clr_dropped", 32'(bcd_carry), 32'h000);

        // mr mid-count with tally 0x042 and an event pending
        do_reset();
        for (int i = 1; i <= 421; i++) step(i % 10, 1'b0, 1'b0);
        step(2, 1'b1, 1'b0);
        chk("mr_pre_carry", 32'(bcd_carry), 32'h042);
        chk("mr_pre_units", 32'(bcd_units), 32'd1);
        for (int i = 423; i <= 430; i++) step(i % 10, 1'b0, 1'b0);
        tick(10'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("mr_live", 32'(live_units), 32'd0);
        chk("mr_units", 32'(bcd_units), 32'd0);
        chk("mr_carry", 32'(bcd_carry), 32'd0);
        chk("mr_illegal", 32'(illegal), 32'd0);
        chk("mr_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0);
        chk("mr_no_spurious", 32'(bcd_carry), 32'd0);
        chk("mr_live_after", 32'(live_units), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ln4017_decade_tally.md
Name: ln4017_decade_tally

Overview:
- Downstream consumer of the decade (4017-style) counter's one-hot output `in_q[9:0]` and its `q59_n` carry.
- Decodes the one-hot state to a BCD units digit.
- Counts decade roll-overs into a cascaded BCD carry register and latches the combined value for display on request.
- Flags illegal, non-one-hot counter states and cascade overflow.

Parameters:
- DIGITS, 3, number of cascaded BCD carry digits above units (1..8).

Ports:
- cp0  input  1  clock; all state changes on rising edge.
- mr  input  1  reset, synchronous, active-high.
- in_q  input  10  one-hot counter state from the decade counter.
- q59_n  input  1  decade counter carry (1 while state 0..4).
- clr  input  1  synchronous clear of the tally (cascade digits, flags).
- latch_en  input  1  capture the current tally into the display registers.
- bcd_units  output  4  latched units digit (0..9).
- bcd_carry  output  4*DIGITS  latched cascade digits; nibble 0 = tens.
- live_units  output  4  unlatched decoded units digit.
- illegal  output  1  sticky: a non-one-hot in_q was sampled.
- ovf  output  1  sticky: cascade wrapped from all-9s to all-0s.

Behaviour:
- Input stage:
  - in_q and q59_n are registered every cycle (s_q, s_c). All decode works from the registered copies.
  - Latency from in_q to live_units is 1 cycle.
- Decode:
  - If s_q has exactly one bit set at position i, live_units = i.
  - Otherwise live_units holds its previous value and illegal sets.
  - All-zero s_q counts as illegal.
- Carry detect:
  - c_prev holds s_c from the previous cycle.
  - A carry event is s_c = 1 with c_prev = 0, i.e. the counter stepped 9 to 0.
  - At most one increment per cycle.
  - A carry event while s_q is illegal still counts.
- Cascade:
  - DIGITS BCD digits.
  - On a carry event, digit 0 increments. A digit at 9 wraps to 0 and propagates the increment to the next digit in the same cycle.
  - When all digits are 9, an event wraps them all to 0 and sets ovf.
  - Digits never take values 10..15.
- Latch: when latch_en = 1 at edge k, bcd_units/bcd_carry take live_units and the cascade values held before edge k. The displayed value is therefore the tally one cycle before capture; an event at edge k does not appear.
- clr = 1:
  - Cascade digits, illegal and ovf go to 0 at the next edge.
  - s_q, s_c, c_prev and live_units continue normal operation.
  - A carry event in the same cycle is discarded.
  - latch_en in the same cycle captures the pre-clear values.
- mr = 1 (overrides clr and latch_en):
  - s_q = 10'b1, s_c = 1, c_prev = 1.
  - live_units = 0, all cascade digits 0.
  - bcd_units = 0, bcd_carry = 0.
  - illegal = 0, ovf = 0.
  - No carry event is generated on the first cycle after mr releases while q59_n is 1.
- mr asserted mid-count: everything above applies on the next edge, regardless of pending events.

Test Plan:
- Reset then walk: assert mr 2 cycles, drive in_q = 1<<n for n = 0..9, one per cycle, q59_n = (n<5) -> live_units follows n with 1-cycle lag; no carry event; bcd_carry = 0 after latch.
- Roll-over: run 23 full decades plus 4 steps, then pulse latch_en -> bcd_units = 4, bcd_carry = 0x023 (DIGITS = 3); ovf = 0.
- Overflow: preload by clocking 999 decades, then one more -> cascade = 0x000, ovf = 1; ovf stays 1 until clr or mr.
- Illegal state: drive in_q = 10'b0000000110 for one cycle, then 1<<7 -> illegal = 1 sticky; live_units holds the prior value during the bad cycle, then becomes 7.
- Simultaneous clr, latch_en and a q59_n rising edge with the tally at 0x015 -> bcd_carry latches 0x015; cascade becomes 0x000 (event dropped); illegal and ovf cleared.
- mr mid-count with the tally at 0x042 and q59_n = 1 held after release -> all outputs 0 next edge; no spurious increment on the following cycles.
